// File: rtl/ps2_line_editor.sv
// rtl/ps2_line_editor.sv - PS/2 deframer, Set-2 decoder and line buffer with valid/ready line handoff
module ps2_line_editor #(
  parameter int MAX_CHARS      = 32,
  parameter int CHAR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int LEN_W          = $clog2(MAX_CHARS + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        ps2_clk_in,
  input  logic                        ps2_data_in,
  output logic                        key_valid_out,
  output logic [CHAR_W-1:0]           char_out,
  output logic                        bksp_out,
  output logic                        overflow_out,
  output logic                        frame_err_out,
  output logic                        line_valid_out,
  input  logic                        line_ready_in,
  output logic [MAX_CHARS*CHAR_W-1:0] line_out,
  output logic [LEN_W-1:0]            line_len_out
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {LB_EDIT, LB_LOCKED} lb_state_t;

  logic [2:0]              r_clk_sync;
  logic [1:0]              r_dat_sync;
  logic                    r_fall;
  logic                    r_bit;
  rx_state_t               r_rx_state;
  rx_state_t               w_rx_next;
  logic [7:0]              r_rx_sr;
  logic [2:0]              r_rx_cnt;
  logic                    r_rx_par;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    w_timeout;
  logic                    w_stb;
  logic                    w_err;
  logic                    r_stb;
  logic [7:0]              r_byte;
  logic                    r_ferr;
  logic                    r_brk;
  logic                    r_ext;
  logic                    r_shift;
  logic [6:0]              w_code;
  logic                    w_letter;
  logic                    w_printable;
  logic                    w_enter;
  logic                    w_bksp;
  logic [CHAR_W-1:0]       w_char;
  lb_state_t               r_lb_state;
  lb_state_t               w_lb_next;
  logic [LEN_W-1:0]        r_len;
  logic [MAX_CHARS*CHAR_W-1:0] r_line;
  logic                    r_key;
  logic [CHAR_W-1:0]       r_char;
  logic                    r_bksp;
  logic                    r_ovf;
  logic                    w_full;

  // Sync FFs reset high so a reset never manufactures a clock fall.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
      r_fall     <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_data_in};
      r_fall     <= r_clk_sync[2] & ~r_clk_sync[1];
      r_bit      <= r_dat_sync[1];
    end
  end

  assign w_timeout = (r_rx_state != RX_IDLE) && !r_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_rx_next = r_rx_state;
    w_stb     = 1'b0;
    w_err     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_fall) begin
          if (!r_bit) w_rx_next = RX_DATA;
          else        w_err     = 1'b1;
        end
      end
      RX_DATA: begin
        if (r_fall && (r_rx_cnt == 3'd7)) w_rx_next = RX_PARITY;
      end
      RX_PARITY: begin
        if (r_fall) w_rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (r_fall) begin
          w_rx_next = RX_IDLE;
          if (r_bit && (^{r_rx_par, r_rx_sr})) w_stb = 1'b1;
          else                                 w_err = 1'b1;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
    if (w_timeout) begin
      w_rx_next = RX_IDLE;
      w_err     = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rx_state <= RX_IDLE;
      r_rx_sr    <= 8'h00;
      r_rx_cnt   <= 3'd0;
      r_rx_par   <= 1'b0;
      r_to_cnt   <= '0;
      r_stb      <= 1'b0;
      r_byte     <= 8'h00;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_stb      <= w_stb;
      r_ferr     <= w_err;
      if (w_stb) r_byte <= r_rx_sr;
      if ((r_rx_state == RX_IDLE) || r_fall) r_to_cnt <= '0;
      else                                   r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_fall) begin
        case (r_rx_state)
          RX_IDLE:   r_rx_cnt <= 3'd0;
          RX_DATA: begin
            r_rx_sr  <= {r_bit, r_rx_sr[7:1]};
            r_rx_cnt <= r_rx_cnt + 3'd1;
          end
          RX_PARITY: r_rx_par <= r_bit;
          default:   r_rx_cnt <= 3'd0;
        endcase
      end
    end
  end

  always_comb begin
    w_code      = 7'h00;
    w_letter    = 1'b0;
    w_printable = 1'b0;
    w_enter     = 1'b0;
    w_bksp      = 1'b0;
    if (r_stb && !r_brk && (r_byte != 8'hF0) && (r_byte != 8'hE0) &&
        (r_byte != 8'h12) && (r_byte != 8'h59)) begin
      if (r_ext) begin
        w_enter = (r_byte == 8'h5A);
      end else begin
        case (r_byte)
          8'h5A: w_enter = 1'b1;
          8'h66: w_bksp  = 1'b1;
          8'h1C: begin w_code = 7'h61; w_letter = 1'b1; end
          8'h32: begin w_code = 7'h62; w_letter = 1'b1; end
          8'h21: begin w_code = 7'h63; w_letter = 1'b1; end
          8'h23: begin w_code = 7'h64; w_letter = 1'b1; end
          8'h24: begin w_code = 7'h65; w_letter = 1'b1; end
          8'h2B: begin w_code = 7'h66; w_letter = 1'b1; end
          8'h34: begin w_code = 7'h67; w_letter = 1'b1; end
          8'h33: begin w_code = 7'h68; w_letter = 1'b1; end
          8'h43: begin w_code = 7'h69; w_letter = 1'b1; end
          8'h3B: begin w_code = 7'h6A; w_letter = 1'b1; end
          8'h42: begin w_code = 7'h6B; w_letter = 1'b1; end
          8'h4B: begin w_code = 7'h6C; w_letter = 1'b1; end
          8'h3A: begin w_code = 7'h6D; w_letter = 1'b1; end
          8'h31: begin w_code = 7'h6E; w_letter = 1'b1; end
          8'h44: begin w_code = 7'h6F; w_letter = 1'b1; end
          8'h4D: begin w_code = 7'h70; w_letter = 1'b1; end
          8'h15: begin w_code = 7'h71; w_letter = 1'b1; end
          8'h2D: begin w_code = 7'h72; w_letter = 1'b1; end
          8'h1B: begin w_code = 7'h73; w_letter = 1'b1; end
          8'h2C: begin w_code = 7'h74; w_letter = 1'b1; end
          8'h3C: begin w_code = 7'h75; w_letter = 1'b1; end
          8'h2A: begin w_code = 7'h76; w_letter = 1'b1; end
          8'h1D: begin w_code = 7'h77; w_letter = 1'b1; end
          8'h22: begin w_code = 7'h78; w_letter = 1'b1; end
          8'h35: begin w_code = 7'h79; w_letter = 1'b1; end
          8'h1A: begin w_code = 7'h7A; w_letter = 1'b1; end
          8'h16: begin w_code = 7'h31; w_printable = 1'b1; end
          8'h1E: begin w_code = 7'h32; w_printable = 1'b1; end
          8'h26: begin w_code = 7'h33; w_printable = 1'b1; end
          8'h25: begin w_code = 7'h34; w_printable = 1'b1; end
          8'h2E: begin w_code = 7'h35; w_printable = 1'b1; end
          8'h36: begin w_code = 7'h36; w_printable = 1'b1; end
          8'h3D: begin w_code = 7'h37; w_printable = 1'b1; end
          8'h3E: begin w_code = 7'h38; w_printable = 1'b1; end
          8'h46: begin w_code = 7'h39; w_printable = 1'b1; end
          8'h45: begin w_code = 7'h30; w_printable = 1'b1; end
          8'h29: begin w_code = 7'h20; w_printable = 1'b1; end
          8'h41: begin w_code = 7'h2C; w_printable = 1'b1; end
          8'h49: begin w_code = 7'h2E; w_printable = 1'b1; end
          default: w_code = 7'h00;
        endcase
        if (w_letter) begin
          w_printable = 1'b1;
          if (r_shift) w_code = w_code - 7'h20;
        end
      end
    end
  end

  assign w_char = {{(CHAR_W - 7){1'b0}}, w_code};

  // Prefix flags live until the next non-prefix byte has been consumed.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
      r_shift <= 1'b0;
    end else if (r_stb) begin
      if (r_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (r_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
        if ((r_byte == 8'h12) || (r_byte == 8'h59)) r_shift <= ~r_brk;
      end
    end
  end

  always_comb begin
    w_lb_next = r_lb_state;
    case (r_lb_state)
      LB_EDIT:   if (w_enter)       w_lb_next = LB_LOCKED;
      LB_LOCKED: if (line_ready_in) w_lb_next = LB_EDIT;
      default:   w_lb_next = LB_EDIT;
    endcase
  end

  assign w_full = (r_len == LEN_W'(MAX_CHARS));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_lb_state <= LB_EDIT;
      r_len      <= '0;
      r_line     <= '0;
      r_key      <= 1'b0;
      r_char     <= '0;
      r_bksp     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_lb_state <= w_lb_next;
      r_key      <= 1'b0;
      r_char     <= '0;
      r_bksp     <= 1'b0;
      r_ovf      <= 1'b0;
      if (r_lb_state == LB_LOCKED) begin
        if (w_printable) r_ovf <= 1'b1;
        if (line_ready_in) begin
          r_len  <= '0;
          r_line <= '0;
        end
      end else if (w_printable) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          for (int i = 0; i < MAX_CHARS; i++)
            if (i == int'(r_len)) r_line[i*CHAR_W +: CHAR_W] <= w_char;
          r_len  <= r_len + LEN_W'(1);
          r_key  <= 1'b1;
          r_char <= w_char;
        end
      end else if (w_bksp && (r_len != '0)) begin
        for (int i = 0; i < MAX_CHARS; i++)
          if (i + 1 == int'(r_len)) r_line[i*CHAR_W +: CHAR_W] <= '0;
        r_len  <= r_len - LEN_W'(1);
        r_bksp <= 1'b1;
      end
    end
  end

  assign key_valid_out  = r_key;
  assign char_out       = r_char;
  assign bksp_out       = r_bksp;
  assign overflow_out   = r_ovf;
  assign frame_err_out  = r_ferr;
  assign line_valid_out = (r_lb_state == LB_LOCKED);
  assign line_out       = r_line;
  assign line_len_out   = r_len;

endmodule

// File: tb/tb_ps2_line_editor.sv
// tb/tb_ps2_line_editor.sv - directed bench for ps2_line_editor with a small buffer and short timeout
module tb_ps2_line_editor;

  localparam int MC    = 4;
  localparam int CW    = 8;
  localparam int TO    = 200;
  localparam int LW    = $clog2(MC + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_dat = 1'b1;
  logic             key_valid;
  logic [CW-1:0]    char_o;
  logic             bksp;
  logic             ovf;
  logic             ferr;
  logic             line_valid;
  logic             line_ready = 1'b0;
  logic [MC*CW-1:0] line_o;
  logic [LW-1:0]    line_len;

  int errors = 0;
  int checks = 0;
  int cnt_key = 0;
  int cnt_bksp = 0;
  int cnt_ovf = 0;
  int cnt_ferr = 0;
  int cnt_lv = 0;
  logic [7:0] char_q[$];

  ps2_line_editor #(
    .MAX_CHARS(MC), .CHAR_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_dat),
    .key_valid_out(key_valid), .char_out(char_o), .bksp_out(bksp),
    .overflow_out(ovf), .frame_err_out(ferr), .line_valid_out(line_valid),
    .line_ready_in(line_ready), .line_out(line_o), .line_len_out(line_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) begin
      cnt_key++;
      char_q.push_back(char_o);
    end
    if (bksp)       cnt_bksp++;
    if (ovf)        cnt_ovf++;
    if (ferr)       cnt_ferr++;
    if (line_valid) cnt_lv++;
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Returns 4 negedges after the stop-bit clock fall.
  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({key_valid, bksp, ovf, ferr, line_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 00000", {key_valid, bksp, ovf, ferr, line_valid});
    end
    checks++;
    if (char_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_char: got %h expected 00", char_o);
    end
    checks++;
    if (line_len !== 0 || line_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_line: got len=%0d line=%h expected len=0 line=0", line_len, line_o);
    end
  endtask

  task automatic test_first_key();
    int k0;
    k0 = cnt_key;
    send_frame(8'h1C, 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: got key_valid=%b expected 0 at 3 cycles", key_valid);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || char_o !== 8'h61) begin
      errors++;
      $display("FAIL lat_pulse: got key_valid=%b char=%h expected 1/61", key_valid, char_o);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || char_o !== 8'h00) begin
      errors++;
      $display("FAIL lat_width: got key_valid=%b char=%h expected 0/00", key_valid, char_o);
    end
    checks++;
    if (line_len !== 1 || line_o !== 32'h00000061 || cnt_key - k0 !== 1) begin
      errors++;
      $display("FAIL first_line: got len=%0d line=%h keys=%0d expected 1/00000061/1", line_len, line_o, cnt_key - k0);
    end
  endtask

  task automatic test_shift();
    int k0, q0;
    logic [7:0] seq [7];
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    do_reset();
    k0 = cnt_key;
    q0 = char_q.size();
    for (int i = 0; i < 7; i++) send_byte(seq[i]);
    checks++;
    if (cnt_key - k0 !== 2) begin
      errors++;
      $display("FAIL shift_count: got %0d key pulses expected 2", cnt_key - k0);
    end else begin
      checks++;
      if (char_q[q0] !== 8'h41 || char_q[q0+1] !== 8'h61) begin
        errors++;
        $display("FAIL shift_chars: got %h %h expected 41 61", char_q[q0], char_q[q0+1]);
      end
    end
    checks++;
    if (line_len !== 2 || line_o !== 32'h00006141) begin
      errors++;
      $display("FAIL shift_line: got len=%0d line=%h expected 2/00006141", line_len, line_o);
    end
  endtask

  task automatic test_frame_err();
    int k0, f0;
    k0 = cnt_key;
    f0 = cnt_ferr;
    send_byte(8'h1C);
    k0 = cnt_key;
    f0 = cnt_ferr;
    send_frame(8'h1C, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_ferr - f0 !== 1 || cnt_key - k0 !== 0) begin
      errors++;
      $display("FAIL parity_err: got ferr=%0d keys=%0d expected 1/0", cnt_ferr - f0, cnt_key - k0);
    end
    f0 = cnt_ferr;
    ps2_bit(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_ferr - f0 !== 1) begin
      errors++;
      $display("FAIL start_err: got ferr=%0d expected 1", cnt_ferr - f0);
    end
    f0 = cnt_ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TO + 20) @(negedge clk);
    checks++;
    if (cnt_ferr - f0 !== 1 || cnt_key - k0 !== 0) begin
      errors++;
      $display("FAIL timeout_err: got ferr=%0d keys=%0d expected 1/0", cnt_ferr - f0, cnt_key - k0);
    end
    send_byte(8'h32);
    checks++;
    if (cnt_key - k0 !== 1 || char_q[char_q.size()-1] !== 8'h62 || line_len !== 4) begin
      errors++;
      $display("FAIL after_err: got keys=%0d char=%h len=%0d expected 1/62/4", cnt_key - k0, char_q[char_q.size()-1], line_len);
    end
  endtask

  task automatic test_overflow();
    int k0, o0, b0;
    do_reset();
    k0 = cnt_key;
    o0 = cnt_ovf;
    for (int i = 0; i < MC + 1; i++) send_byte(8'h1C);
    checks++;
    if (cnt_key - k0 !== MC || cnt_ovf - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_counts: got keys=%0d ovf=%0d expected 4/1", cnt_key - k0, cnt_ovf - o0);
    end
    checks++;
    if (line_len !== 4 || line_o !== 32'h61616161) begin
      errors++;
      $display("FAIL ovf_line: got len=%0d line=%h expected 4/61616161", line_len, line_o);
    end
    b0 = cnt_bksp;
    send_byte(8'h66);
    checks++;
    if (line_len !== 3 || line_o !== 32'h00616161) begin
      errors++;
      $display("FAIL bksp_one: got len=%0d line=%h expected 3/00616161", line_len, line_o);
    end
    for (int i = 0; i < MC; i++) send_byte(8'h66);
    checks++;
    if (cnt_bksp - b0 !== MC || line_len !== 0 || line_o !== 32'h0) begin
      errors++;
      $display("FAIL bksp_all: got bksp=%0d len=%0d line=%h expected 4/0/0", cnt_bksp - b0, line_len, line_o);
    end
  endtask

  task automatic test_line();
    int k0, o0, b0, l0;
    do_reset();
    line_ready = 1'b0;
    k0 = cnt_key;
    send_byte(8'h16);
    send_byte(8'h29);
    send_byte(8'h1E);
    send_byte(8'h5A);
    repeat (10) @(negedge clk);
    checks++;
    if (line_valid !== 1'b1 || line_len !== 3 || line_o !== 32'h00322031 || cnt_key - k0 !== 3) begin
      errors++;
      $display("FAIL line_hold: got valid=%b len=%0d line=%h keys=%0d expected 1/3/00322031/3", line_valid, line_len, line_o, cnt_key - k0);
    end
    o0 = cnt_ovf;
    b0 = cnt_bksp;
    send_byte(8'h22);
    send_byte(8'h66);
    checks++;
    if (cnt_ovf - o0 !== 1 || cnt_bksp - b0 !== 0 || line_valid !== 1'b1 || line_len !== 3 || line_o !== 32'h00322031) begin
      errors++;
      $display("FAIL locked_drop: got ovf=%0d bksp=%0d valid=%b len=%0d line=%h expected 1/0/1/3/00322031",
               cnt_ovf - o0, cnt_bksp - b0, line_valid, line_len, line_o);
    end
    line_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (line_valid !== 1'b0 || line_len !== 0 || line_o !== 32'h0) begin
      errors++;
      $display("FAIL line_accept: got valid=%b len=%0d line=%h expected 0/0/0", line_valid, line_len, line_o);
    end
    l0 = cnt_lv;
    send_byte(8'hE0);
    send_byte(8'h5A);
    checks++;
    if (cnt_lv - l0 !== 1 || line_valid !== 1'b0 || line_len !== 0) begin
      errors++;
      $display("FAIL empty_line: got valid_cycles=%0d valid=%b len=%0d expected 1/0/0", cnt_lv - l0, line_valid, line_len);
    end
    line_ready = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    int k0, f0, o0;
    f0 = cnt_ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    do_reset();
    checks++;
    if ({key_valid, bksp, ovf, ferr, line_valid} !== 5'b0 || line_len !== 0) begin
      errors++;
      $display("FAIL midframe_rst: got %b len=%0d expected 00000/0", {key_valid, bksp, ovf, ferr, line_valid}, line_len);
    end
    repeat (TO + 20) @(negedge clk);
    checks++;
    if (cnt_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL midframe_noerr: got ferr=%0d expected 0", cnt_ferr - f0);
    end
    k0 = cnt_key;
    send_byte(8'h1C);
    checks++;
    if (cnt_key - k0 !== 1 || char_q[char_q.size()-1] !== 8'h61 || line_len !== 1) begin
      errors++;
      $display("FAIL post_rst_key: got keys=%0d char=%h len=%0d expected 1/61/1", cnt_key - k0, char_q[char_q.size()-1], line_len);
    end
    send_byte(8'h5A);
    checks++;
    if (line_valid !== 1'b1) begin
      errors++;
      $display("FAIL lock_before_rst: got valid=%b expected 1", line_valid);
    end
    do_reset();
    checks++;
    if (line_valid !== 1'b0 || line_len !== 0 || line_o !== 32'h0) begin
      errors++;
      $display("FAIL locked_rst: got valid=%b len=%0d line=%h expected 0/0/0", line_valid, line_len, line_o);
    end
    k0 = cnt_key;
    o0 = cnt_ovf;
    send_byte(8'h1C);
    checks++;
    if (cnt_key - k0 !== 1 || cnt_ovf - o0 !== 0 || line_len !== 1) begin
      errors++;
      $display("FAIL post_lock_rst: got keys=%0d ovf=%0d len=%0d expected 1/0/1", cnt_key - k0, cnt_ovf - o0, line_len);
    end
  endtask

  initial begin
    test_reset();
    test_first_key();
    test_shift();
    test_frame_err();
    test_overflow();
    test_line();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
